// File: rtl/pixel_top.sv
// Frame sequencer for a 2x2 pixel block: erase, expose, convert, then four
// back-to-back row reads, looping forever. Strobes decode from registered state.
//
// state   | meaning
// IDLE    | one all-zero cycle between frames (and after reset)
// ERASE   | pixel reset strobe
// EXPOSE  | integration window
// CONVERT | ADC ramp/counter running
// READ1-4 | per-pixel readout enable
module pixel_top #(
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 255,
    parameter int READ_CYCLES    = 5,
    parameter int COUNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    output logic erase,
    output logic expose,
    output logic read1,
    output logic read2,
    output logic read3,
    output logic read4,
    output logic convert
);

    typedef enum logic [2:0] {
        IDLE, ERASE, EXPOSE, CONVERT, READ1, READ2, READ3, READ4
    } state_t;

    // Terminal counts are duration-1, so a duration of 2^COUNT_W fits without wrap.
    localparam logic [COUNT_W-1:0] ERASE_TC   = COUNT_W'(ERASE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] EXPOSE_TC  = COUNT_W'(EXPOSE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CONVERT_TC = COUNT_W'(CONVERT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] READ_TC    = COUNT_W'(READ_CYCLES - 1);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] tc;
    logic               done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        tc = READ_TC;
        case (state_q)
            ERASE:   tc = ERASE_TC;
            EXPOSE:  tc = EXPOSE_TC;
            CONVERT: tc = CONVERT_TC;
            default: tc = READ_TC;
        endcase
    end

    assign done = (cnt_q == tc);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + COUNT_W'(1);
        case (state_q)
            IDLE:    state_d = ERASE;
            ERASE:   if (done) state_d = EXPOSE;
            EXPOSE:  if (done) state_d = CONVERT;
            CONVERT: if (done) state_d = READ1;
            READ1:   if (done) state_d = READ2;
            READ2:   if (done) state_d = READ3;
            READ3:   if (done) state_d = READ4;
            READ4:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        erase   = 1'b0;
        expose  = 1'b0;
        convert = 1'b0;
        read1   = 1'b0;
        read2   = 1'b0;
        read3   = 1'b0;
        read4   = 1'b0;
        case (state_q)
            ERASE:   erase   = 1'b1;
            EXPOSE:  expose  = 1'b1;
            CONVERT: convert = 1'b1;
            READ1:   read1   = 1'b1;
            READ2:   read2   = 1'b1;
            READ3:   read3   = 1'b1;
            READ4:   read4   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pixel_top.sv
// Bench for pixel_top: three parameterisations driven from one reset, each
// scored against a frame-position schedule model.
module tb_pixel_top;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // bit order: {erase, expose, convert, read1, read2, read3, read4}
    logic [6:0] out_a, out_b, out_c;

    pixel_top u_a (
        .clk(clk), .reset(reset),
        .erase(out_a[6]), .expose(out_a[5]), .read1(out_a[3]), .read2(out_a[2]),
        .read3(out_a[1]), .read4(out_a[0]), .convert(out_a[4])
    );

    pixel_top #(.ERASE_CYCLES(1), .EXPOSE_CYCLES(2), .CONVERT_CYCLES(3),
                .READ_CYCLES(1), .COUNT_W(8)) u_b (
        .clk(clk), .reset(reset),
        .erase(out_b[6]), .expose(out_b[5]), .read1(out_b[3]), .read2(out_b[2]),
        .read3(out_b[1]), .read4(out_b[0]), .convert(out_b[4])
    );

    // Durations equal to 2^COUNT_W exercise the full-range terminal count.
    pixel_top #(.ERASE_CYCLES(4), .EXPOSE_CYCLES(1), .CONVERT_CYCLES(4),
                .READ_CYCLES(2), .COUNT_W(2)) u_c (
        .clk(clk), .reset(reset),
        .erase(out_c[6]), .expose(out_c[5]), .read1(out_c[3]), .read2(out_c[2]),
        .read3(out_c[1]), .read4(out_c[0]), .convert(out_c[4])
    );

    int de[3] = '{5, 1, 4};
    int dx[3] = '{255, 2, 1};
    int dc[3] = '{255, 3, 4};
    int dr[3] = '{5, 1, 2};
    int per[3];
    int pos[3];

    logic [6:0] sb_q[$];
    int n_vec = 0;
    int n_err = 0;
    int edge_n = -1;
    int wid[3][7];
    int rises[$];
    logic prev_erase = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] model(input int p, input int e, input int x,
                                         input int c, input int r);
        if (p < e) return 7'b1000000;
        p -= e;
        if (p < x) return 7'b0100000;
        p -= x;
        if (p < c) return 7'b0010000;
        p -= c;
        if (p < 4 * r) return 7'b0001000 >> (p / r);
        return 7'b0000000;
    endfunction

    function automatic logic [6:0] dut_out(input int d);
        case (d)
            0: return out_a;
            1: return out_b;
            default: return out_c;
        endcase
    endfunction

    task automatic step(input logic r);
        logic [6:0] got, want;
        @(negedge clk);
        reset = r;
        @(posedge clk);
        edge_n = r ? -1 : edge_n + 1;
        for (int d = 0; d < 3; d++) begin
            pos[d] = r ? per[d] - 1 : (pos[d] + 1) % per[d];
            sb_q.push_back(model(pos[d], de[d], dx[d], dc[d], dr[d]));
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            got  = dut_out(d);
            want = sb_q.pop_front();
            chk($sformatf("vec%0d", d), int'(got), int'(want));
            chk($sformatf("onehot%0d", d), $countones(got) <= 1, 1);
            if (!r && edge_n < per[d])
                for (int b = 0; b < 7; b++) wid[d][b] += int'(got[6-b]);
        end
        if (!r && out_a[6] && !prev_erase) rises.push_back(edge_n);
        prev_erase = out_a[6];
    endtask

    initial begin
        int cnt;
        for (int d = 0; d < 3; d++) begin
            per[d] = 1 + de[d] + dx[d] + dc[d] + 4 * dr[d];
            pos[d] = per[d] - 1;
        end

        // reset hold, then full frames and free-run
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("rst_outs", int'({out_a, out_b, out_c}), 0);
        for (int d = 0; d < 3; d++) for (int b = 0; b < 7; b++) wid[d][b] = 0;
        rises.delete();
        for (int i = 0; i < 1200; i++) step(1'b0);

        chk("period_a", per[0], 536);
        chk("period_b", per[1], 11);
        for (int b = 0; b < 7; b++) begin
            chk($sformatf("wid_a%0d", b), wid[0][b], (b == 0) ? 5 : (b < 3) ? 255 : 5);
            chk($sformatf("wid_b%0d", b), wid[1][b], (b == 1) ? 2 : (b == 2) ? 3 : 1);
            chk($sformatf("wid_c%0d", b), wid[2][b], (b == 0 || b == 2) ? 4 : (b == 1) ? 1 : 2);
        end
        chk("rise_cnt", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("rise0", rises[0], 0);
            chk("rise1", rises[1], 536);
            chk("rise2", rises[2], 1072);
        end

        // mid-frame reset during convert
        step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);
        chk("pre_rst_convert", int'(out_a[4]), 1);
        step(1'b1);
        chk("mid_rst_outs", int'(out_a), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            cnt += int'(out_a[6]);
        end
        chk("post_rst_erase", cnt, 5);

        // random resets
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 49) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
